// File: rtl/mem_bus_master.sv
// Processor-side initiator for the shared memory/IO bus: one load or store at a time, registered bus outputs.
// Optional MEM_BUS_ALIGN_CHK_EN adds resp_err and rejects misaligned requests without running a bus cycle.
module mem_bus_master #(
    parameter int                        ADDR_BIT_WIDTH = 32,
    parameter int                        DATA_BIT_WIDTH = 32,
    parameter int                        READ_WAIT      = 0,
    parameter logic [ADDR_BIT_WIDTH-1:0] PARK_ADDR      = 32'hFFFF_FFFF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDR_BIT_WIDTH-1:0] req_addr,
    input  logic [DATA_BIT_WIDTH-1:0] req_wdata,
    output logic                      resp_valid,
    output logic [DATA_BIT_WIDTH-1:0] resp_rdata,
`ifdef MEM_BUS_ALIGN_CHK_EN
    output logic                      resp_err,
`endif
    output logic [ADDR_BIT_WIDTH-1:0] addr,
    output logic                      writeEn,
    inout  wire  [DATA_BIT_WIDTH-1:0] dataBus,
    output logic [1:0]                dbg_state
);

    // Handshake: a request is taken at a posedge where req_valid & req_ready;
    // the req_* fields are registered at that edge and ignored at all other times.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic                      accept;
    logic [DATA_BIT_WIDTH-1:0] wdata_q;
    logic [3:0]                wait_cnt;
`ifdef MEM_BUS_ALIGN_CHK_EN
    logic                      misalign;
    assign misalign = (req_addr[1:0] != 2'b00);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_we) state_nxt = WRITE;
                    else        state_nxt = READ;
`ifdef MEM_BUS_ALIGN_CHK_EN
                    if (misalign) state_nxt = DONE;
`endif
                end
            end
            WRITE:   state_nxt = DONE;
            READ:    if (wait_cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE) & ~reset;
        accept    = req_valid & req_ready;
        dbg_state = state;
    end

    // The data bus is driven only while the registered write strobe is high.
    assign dataBus = writeEn ? wdata_q : {DATA_BIT_WIDTH{1'bz}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr       <= PARK_ADDR;
            writeEn    <= 1'b0;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            wait_cnt   <= 4'd0;
`ifdef MEM_BUS_ALIGN_CHK_EN
            resp_err   <= 1'b0;
`endif
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr     <= req_addr;
                        writeEn  <= req_we;
                        wdata_q  <= req_wdata;
                        wait_cnt <= 4'(READ_WAIT);
`ifdef MEM_BUS_ALIGN_CHK_EN
                        resp_err <= 1'b0;
                        // Misaligned: keep the bus parked and answer straight away.
                        if (misalign) begin
                            addr       <= PARK_ADDR;
                            writeEn    <= 1'b0;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end
`endif
                    end
                end
                WRITE: begin
                    writeEn    <= 1'b0;
                    addr       <= PARK_ADDR;
                    resp_valid <= 1'b1;
                end
                READ: begin
                    if (wait_cnt == 4'd0) begin
                        resp_rdata <= dataBus;
                        resp_valid <= 1'b1;
                        addr       <= PARK_ADDR;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
